bitscan_encoder: RTL and testbench
==================================

Name: bitscan_encoder

Overview:
- Sequential encoder; the inverse direction of the team's bitwise decoder.
- Accepts a multi-hot N-bit vector over a valid/ready handshake.
- Emits the binary index of every set bit, lowest first, one index per output handshake, and flags the last one.
- Sits between request/flag producers and index-consuming logic such as arbiters and interrupt dispatch.

Parameters:
N, 4, input vector width (N >= 2)
W, 2, index width; must equal ceil(log2(N))

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_vec is valid
in_ready  output  1  block can accept a vector
in_vec  input  N  multi-hot vector to encode
out_valid  output  1  out_idx/out_last/out_none valid
out_ready  input  1  consumer accepts the current output
out_idx  output  W  index of current lowest set bit
out_last  output  1  current index is the final one for this vector
out_none  output  1  accepted vector was all-zero; out_idx is 0

Behaviour:
- Clock and reset: one clock domain on clk. Reset is asynchronous, active-low (rst_n), with synchronous deassertion handled upstream.
- Reset values:
  - state=IDLE, pending=0
  - in_ready=1, out_valid=0, out_idx=0, out_last=0, out_none=0
- Storage: all outputs registered. in_ready = (state==IDLE).
- IDLE:
  - On in_valid & in_ready, capture in_vec into pending and go to EMIT.
  - Next cycle (latency 1): out_valid=1 and out_idx = lowest set bit of in_vec.
  - out_last=1 iff exactly one bit is set.
  - If in_vec==0: out_none=1, out_idx=0, out_last=1.
- EMIT:
  - out_valid held at 1 with all outputs stable until out_ready.
  - On out_valid & out_ready with out_last=0: clear bit out_idx in pending. Next cycle presents the next lowest set bit and recomputes out_last. No bubble cycles.
  - On out_valid & out_ready with out_last=1: clear pending and go to IDLE. Next cycle out_valid=0, out_none=0, out_last=0, in_ready=1.
- Throughput: a vector with k set bits occupies k output beats plus 1 accept cycle. No overlap of the accept with the final beat.
- Priority: bit 0 is highest priority. Ties are impossible, since one index is emitted per beat.
- Arithmetic: out_idx is the W-bit zero-extended bit position. Bits of in_vec above index N-1 do not exist; W must fit N-1.
- in_vec changes while in EMIT are ignored; in_valid is not sampled.
- out_ready held high continuously gives one index per cycle.
- All-ones vector: N beats with indices 0..N-1; out_last only on index N-1.
- Reset mid-operation: rst_n low at any point immediately forces the reset values. The pending vector is discarded, with no partial output after release.
- No combinational path from in_valid, in_vec or out_ready to any output.

Decomposition:
- Shared package/header `bitscan_pkg`:
  - state encoding constants ST_IDLE=1'b0, ST_EMIT=1'b1
  - default N/W constants
  - a width-check macro, so an illegal (N, W) pair fails elaboration.
- One natural sub-module: `lsb_priority_encoder`. Combinational, parameterised by N/W.
  - Inputs: vec[N-1:0].
  - Outputs: idx[W-1:0], any, single (exactly one bit set).
  - Instantiated twice: once on in_vec for the accept path and once on the next-pending value for the emit path.
  - Alternatively, instantiate it once on a muxed source.
- The top holds the FSM, the pending register and the output registers.

Test Plan:
- Reset behaviour: assert rst_n=0 mid-stream, then release -> in_ready=1, out_valid=0, out_idx=0 on the cycle after release. No stale output.
- Sparse vector: in_vec=4'b1010, out_ready=1 -> beat 1: idx=1, last=0; beat 2: idx=3, last=1; then in_ready=1.
- Zero vector: in_vec=4'b0000 -> one beat with out_none=1, out_idx=0, out_last=1; then back to IDLE.
- Backpressure: in_vec=4'b0111, out_ready low for 3 cycles -> idx=0 held stable. Releasing out_ready gives 0, 1, 2 on consecutive cycles, last on 2.
- Ignored input: in_vec=4'b1111 accepted, then in_valid toggled with 4'b0001 during EMIT -> in_ready=0 throughout. Output is 0, 1, 2, 3 only.
- Back-to-back vectors: 4'b1000 then 4'b0001 with in_valid held -> idx=3 (last), one idle/accept cycle, then idx=0 (last).

Source files
------------

// File: rtl/bitscan_pkg.sv
// Shared constants for the bitscan encoder: state encoding, default sizes,
// and an elaboration-time check that the index width matches the vector width.
`ifndef BITSCAN_PKG_SV
`define BITSCAN_PKG_SV

// Drop inside a module body; an illegal (N, W) pair stops elaboration.
`define BITSCAN_WIDTH_CHECK(n_, w_) \
  if (((n_) < 2) || ((w_) != $clog2(n_))) begin : g_width_check \
    $error("bitscan: illegal N/W pair, need N >= 2 and W == clog2(N)"); \
  end

package bitscan_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  localparam int DEF_N = 4;
  localparam int DEF_W = 2;

endpackage

`endif

// File: rtl/lsb_priority_encoder.sv
// Combinational lowest-set-bit encoder: index of the lowest set bit, whether
// any bit is set, and whether exactly one bit is set. idx is 0 when vec is 0.
module lsb_priority_encoder
  import bitscan_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         single
);

  `BITSCAN_WIDTH_CHECK(N, W)

  logic [N-1:0] vec_minus_one;

  // Scan high to low so the lowest set bit wins; clearing the lowest bit
  // with vec & (vec-1) leaves zero only for one-hot inputs.
  always_comb begin
    idx           = '0;
    vec_minus_one = vec - N'(1);
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
    any    = |vec;
    single = any && ((vec & vec_minus_one) == '0);
  end

endmodule

// File: rtl/bitscan_encoder.sv
// Sequential multi-hot to index encoder. Accepts a vector in IDLE, then
// emits the index of every set bit lowest first, one per output handshake,
// flagging the final one. All outputs are registered.
module bitscan_encoder
  import bitscan_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_none
);

  `BITSCAN_WIDTH_CHECK(N, W)

  state_t       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] pend_next;
  logic [W-1:0] idx_d;
  logic         vld_d, last_d, none_d;

  logic [W-1:0] acc_idx, emit_idx;
  logic         acc_any, acc_single;
  logic         emit_any, emit_single;

  // Accept path: encode the incoming vector directly.
  lsb_priority_encoder #(.N(N), .W(W)) u_pe_acc (
    .vec    (in_vec),
    .idx    (acc_idx),
    .any    (acc_any),
    .single (acc_single)
  );

  // Emit path: encode what remains once the current index is consumed.
  lsb_priority_encoder #(.N(N), .W(W)) u_pe_emit (
    .vec    (pend_next),
    .idx    (emit_idx),
    .any    (emit_any),
    .single (emit_single)
  );

  assign in_ready = (state_q == ST_IDLE);

  // Next-state and next-output logic; everything holds unless a handshake fires.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    vld_d     = out_valid;
    idx_d     = out_idx;
    last_d    = out_last;
    none_d    = out_none;
    pend_next = pend_q;
    pend_next[out_idx] = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_EMIT;
          pend_d  = in_vec;
          vld_d   = 1'b1;
          idx_d   = acc_idx;
          // An all-zero vector still produces one terminating beat.
          last_d  = !acc_any || acc_single;
          none_d  = !acc_any;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (out_last) begin
            state_d = ST_IDLE;
            pend_d  = '0;
            vld_d   = 1'b0;
            idx_d   = '0;
            last_d  = 1'b0;
            none_d  = 1'b0;
          end else begin
            // emit_any is guaranteed here since out_last was 0.
            pend_d = pend_next;
            idx_d  = emit_idx;
            last_d = emit_single || !emit_any;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pending vector and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_none  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      out_valid <= vld_d;
      out_idx   <= idx_d;
      out_last  <= last_d;
      out_none  <= none_d;
    end
  end

endmodule

// File: tb/tb_bitscan_encoder.sv
// Bench for bitscan_encoder: table of directed vectors, hand-written corner
// sequences, and random vectors checked against a bit-list reference model.
module tb_bitscan_encoder;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_vec = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic         out_none;

  int n_vec = 0;
  int n_err = 0;

  bitscan_encoder #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_none  (out_none)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] vec;
    int           nb;
    int           idx[4];
    bit           none;
    int           stall;
    bit           junk;
  } vec_rec_t;

  vec_rec_t tbl[8];

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: ascending list of set-bit positions.
  function automatic void model(input logic [N-1:0] v, output int q[$], output bit none);
    q = {};
    for (int p = 0; p < N; p++) if (v[p]) q.push_back(p);
    none = (q.size() == 0);
    if (none) q.push_back(0);
  endfunction

  // Accept one vector, then walk its beats with optional stalls and
  // in_valid noise during emission. Called just after a rising edge.
  task automatic run_one(input logic [N-1:0] v, input int stall, input bit junk,
                         input int exp_q[$], input bit exp_none);
    int lim;
    lim = 0;
    while (!in_ready && lim < 20) begin
      step();
      lim++;
    end
    chk("accept_ready", int'(in_ready), 1);
    in_valid = 1'b1;
    in_vec   = v;
    step();
    in_valid = junk;
    in_vec   = 4'b0001;
    for (int b = 0; b < exp_q.size(); b++) begin
      for (int s = 0; s < stall; s++) begin
        out_ready = 1'b0;
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_idx", int'(out_idx), exp_q[b]);
        step();
      end
      chk("beat_valid", int'(out_valid), 1);
      chk("beat_idx", int'(out_idx), exp_q[b]);
      chk("beat_last", int'(out_last), (b == exp_q.size() - 1) ? 1 : 0);
      chk("beat_none", int'(out_none), int'(exp_none));
      chk("emit_ready", int'(in_ready), 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    in_valid = 1'b0;
    chk("done_valid", int'(out_valid), 0);
    chk("done_ready", int'(in_ready), 1);
    chk("done_last", int'(out_last), 0);
    chk("done_none", int'(out_none), 0);
  endtask

  initial begin
    int q[$];
    bit nn;
    logic [N-1:0] rv;

    tbl[0] = '{4'b1010, 2, '{1, 3, 0, 0}, 1'b0, 0, 1'b0};
    tbl[1] = '{4'b0000, 1, '{0, 0, 0, 0}, 1'b1, 0, 1'b0};
    tbl[2] = '{4'b0111, 3, '{0, 1, 2, 0}, 1'b0, 3, 1'b0};
    tbl[3] = '{4'b1111, 4, '{0, 1, 2, 3}, 1'b0, 0, 1'b1};
    tbl[4] = '{4'b1000, 1, '{3, 0, 0, 0}, 1'b0, 1, 1'b0};
    tbl[5] = '{4'b0001, 1, '{0, 0, 0, 0}, 1'b0, 0, 1'b1};
    tbl[6] = '{4'b0110, 2, '{1, 2, 0, 0}, 1'b0, 2, 1'b1};
    tbl[7] = '{4'b1001, 2, '{0, 3, 0, 0}, 1'b0, 0, 1'b0};

    // Reset state.
    step();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_none", int'(out_none), 0);
    rst_n = 1'b1;
    step();

    // Directed table.
    for (int t = 0; t < 8; t++) begin
      q = {};
      for (int b = 0; b < tbl[t].nb; b++) q.push_back(tbl[t].idx[b]);
      run_one(tbl[t].vec, tbl[t].stall, tbl[t].junk, q, tbl[t].none);
    end

    // Back-to-back with in_valid held: 1000 then 0001.
    in_valid = 1'b1;
    in_vec   = 4'b1000;
    step();
    in_vec    = 4'b0001;
    out_ready = 1'b1;
    chk("b2b_idx0", int'(out_idx), 3);
    chk("b2b_last0", int'(out_last), 1);
    step();
    chk("b2b_gap_valid", int'(out_valid), 0);
    chk("b2b_gap_ready", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("b2b_valid1", int'(out_valid), 1);
    chk("b2b_idx1", int'(out_idx), 0);
    chk("b2b_last1", int'(out_last), 1);
    step();
    out_ready = 1'b0;
    chk("b2b_end_valid", int'(out_valid), 0);

    // Reset mid-stream: accept 1111, take one beat, then reset.
    in_valid = 1'b1;
    in_vec   = 4'b1111;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("mid_idx_before_rst", int'(out_idx), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_async_valid", int'(out_valid), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_idx", int'(out_idx), 0);
    chk("mid_rst_out_last", int'(out_last), 0);
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    chk("mid_rst_no_stale", int'(out_valid), 0);

    // Random vectors against the reference model.
    for (int r = 0; r < 150; r++) begin
      rv = N'($urandom_range(0, (1 << N) - 1));
      model(rv, q, nn);
      run_one(rv, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), q, nn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
